// File: rtl/icache_direct_pkg.sv
// rtl/icache_direct_pkg.sv - shared constants and FSM state type for the direct-mapped icache
package icache_direct_pkg;

    localparam logic        TRUE              = 1'b1;
    localparam logic        FALSE             = 1'b0;
    localparam int          ADDR              = 32;
    localparam int          INSTRLEN          = 32;
    localparam logic [31:0] NULL32            = 32'h0000_0000;
    localparam int          ICACHE_INDEX_BITS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MISS = 2'd1,
        DROP = 2'd2
    } icache_state_e;

endpackage

// File: rtl/icache_direct_array.sv
// rtl/icache_direct_array.sv - valid/tag/data line storage, combinational lookup, synchronous fill
module icache_array #(
    parameter int INDEX_BITS = 8,
    parameter int TAG_W      = 22,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_idx_i,
    input  logic [TAG_W-1:0]      rd_tag_i,
    output logic                  rd_hit_o,
    output logic [DATA_W-1:0]     rd_data_o,
    input  logic                  we_i,
    input  logic [INDEX_BITS-1:0] wr_idx_i,
    input  logic [TAG_W-1:0]      wr_tag_i,
    input  logic [DATA_W-1:0]     wr_data_i
);

    localparam int LINES = 2 ** INDEX_BITS;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    assign rd_hit_o  = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
    assign rd_data_o = data_q[rd_idx_i];

    // Only valid bits need clearing; tag/data are don't-care while invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && we_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped instruction cache between fetch and the memory controller
module icache_direct
    import icache_direct_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int ADDR_W     = ADDR
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                jump_wrong,
    input  logic                if_valid,
    input  logic [ADDR_W-1:0]   if_pc,
    output logic                if_ready,
    output logic [INSTRLEN-1:0] if_instr,
    output logic                mc_read_signal,
    output logic [ADDR_W-1:0]   mc_addr,
    input  logic                mc_success,
    input  logic [INSTRLEN-1:0] mc_instr
);

    localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

    icache_state_e       state_q, state_d;
    logic                if_ready_q, if_ready_d;
    logic [INSTRLEN-1:0] if_instr_q, if_instr_d;
    logic                mc_read_q, mc_read_d;
    logic [ADDR_W-1:0]   mc_addr_q, mc_addr_d;

    logic                rd_hit;
    logic [INSTRLEN-1:0] rd_data;
    logic                fill;

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W),
        .DATA_W     (INSTRLEN)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .rd_idx_i  (if_pc[INDEX_BITS+1:2]),
        .rd_tag_i  (if_pc[ADDR_W-1:INDEX_BITS+2]),
        .rd_hit_o  (rd_hit),
        .rd_data_o (rd_data),
        .we_i      (fill && rdy),
        .wr_idx_i  (mc_addr_q[INDEX_BITS+1:2]),
        .wr_tag_i  (mc_addr_q[ADDR_W-1:INDEX_BITS+2]),
        .wr_data_i (mc_instr)
    );

    // The fill uses the held miss address, so fetch may change if_pc after a flush.
    always_comb begin
        state_d    = state_q;
        if_ready_d = FALSE;
        if_instr_d = if_instr_q;
        mc_read_d  = mc_read_q;
        mc_addr_d  = mc_addr_q;
        fill       = FALSE;
        if (jump_wrong) begin
            state_d   = IDLE;
            mc_read_d = FALSE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (if_valid && !if_ready_q) begin
                        if (rd_hit) begin
                            if_ready_d = TRUE;
                            if_instr_d = rd_data;
                        end else begin
                            mc_addr_d = if_pc & ~ADDR_W'(3);
                            mc_read_d = TRUE;
                            state_d   = MISS;
                        end
                    end
                end
                MISS: begin
                    if (mc_success) begin
                        fill       = TRUE;
                        if_ready_d = TRUE;
                        if_instr_d = mc_instr;
                        mc_read_d  = FALSE;
                        state_d    = DROP;
                    end
                end
                DROP: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            if_ready_q <= FALSE;
            if_instr_q <= NULL32;
            mc_read_q  <= FALSE;
            mc_addr_q  <= '0;
        end else if (rdy) begin
            state_q    <= state_d;
            if_ready_q <= if_ready_d;
            if_instr_q <= if_instr_d;
            mc_read_q  <= mc_read_d;
            mc_addr_q  <= mc_addr_d;
        end
    end

    assign if_ready       = if_ready_q;
    assign if_instr       = if_instr_q;
    assign mc_read_signal = mc_read_q;
    assign mc_addr        = mc_addr_q;

endmodule
